clm_unmask_serial: RTL and testbench

//  Decoder counterpart of the CLM masked multipliers: strips the CLM mask from

---
 rtl/clm_unmask_serial_pkg.sv | 20 ++
 rtl/clm_unmask_serial_if.sv | 28 ++
 rtl/clm_unmask_serial_row_fold.sv | 19 +
 rtl/clm_unmask_serial.sv | 144 ++++++++++++++
 tb/tb_clm_unmask_serial.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/clm_unmask_serial_pkg.sv
`default_nettype none
// ============================================================================
// Module   : clm_unmask_serial_pkg
// Brief    : Shared types for the serial CLM unmasking decoder.
// Revision : 1.0
// ============================================================================
package clm_unmask_serial_pkg;

    // Masking order: number of refresh bits carried with each encoded byte.
    localparam int D = 2;

    typedef logic [0:7+D]      state_t;
    typedef logic [0:6+D][0:7] mc_m_matrix_t;
    typedef logic [0:8]        red_poly_t;
    typedef logic [0:7]        plain_byte_t;
    typedef logic [0:D-1][0:7] mask_rows_t;
    typedef logic [0:D-1]      refresh_bits_t;

endpackage
`default_nettype wire

// File: rtl/clm_unmask_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : clm_unmask_serial_if
// Brief    : Encoded-in / plain-out valid-ready stream bundle.
// Revision : 1.0
// ============================================================================
interface clm_unmask_serial_if;

    logic                                 in_valid;
    logic                                 in_ready;
    clm_unmask_serial_pkg::state_t        in_data;
    logic                                 out_valid;
    logic                                 out_ready;
    clm_unmask_serial_pkg::plain_byte_t   out_data;
    logic                                 out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface
`default_nettype wire

// File: rtl/clm_unmask_serial_row_fold.sv
`default_nettype none
// ============================================================================
// Module   : clm_unmask_serial_row_fold
// Brief    : Folds one gated encoder row into the accumulator (combinational).
// Revision : 1.0
// ============================================================================
module clm_unmask_serial_row_fold
    import clm_unmask_serial_pkg::*;
(
    input  plain_byte_t acc,
    input  logic        r_bit,
    input  plain_byte_t row,
    output plain_byte_t acc_next
);

    assign acc_next = acc ^ ({8{r_bit}} & row);

endmodule
`default_nettype wire

// File: rtl/clm_unmask_serial.sv
`default_nettype none
// ============================================================================
// Module   : clm_unmask_serial
// Brief    : Iterative CLM unmasking: one encoder row folded per cycle.
// Revision : 1.0
// ============================================================================
module clm_unmask_serial
    import clm_unmask_serial_pkg::*;
#(
    parameter int NBYTES = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  mc_m_matrix_t              B_ext_MC,
    clm_unmask_serial_if.slave        strm,
    output logic                      busy
);

    localparam int K_W   = $clog2(D) + 1;
    localparam int CNT_W = $clog2(NBYTES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    if (D < 1) begin : g_d_illegal
        $error("clm_unmask_serial: masking order D must be at least 1");
    end

    logic [1:0]       state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    plain_byte_t      acc_q, acc_d;
    refresh_bits_t    r_q, r_d;
    mask_rows_t       b_q, b_d;

    plain_byte_t      row_sel;
    logic             r_sel;
    plain_byte_t      acc_fold;
    logic             unused_rows;

    // Only rows 0..D-1 of the encoder matrix take part in decoding.
    assign unused_rows = ^B_ext_MC[D:6+D];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            byte_cnt_q <= '0;
            acc_q      <= '0;
            r_q        <= '0;
            b_q        <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            byte_cnt_q <= byte_cnt_d;
            acc_q      <= acc_d;
            r_q        <= r_d;
            b_q        <= b_d;
        end
    end

    always_comb begin
        row_sel = '0;
        r_sel   = 1'b0;
        for (int j = 0; j < D; j++) begin
            if (k_q == K_W'(j)) begin
                row_sel = b_q[j];
                r_sel   = r_q[j];
            end
        end
    end

    clm_unmask_serial_row_fold u_row_fold (
        .acc      (acc_q),
        .r_bit    (r_sel),
        .row      (row_sel),
        .acc_next (acc_fold)
    );

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        byte_cnt_d = byte_cnt_q;
        acc_d      = acc_q;
        r_d        = r_q;
        b_d        = b_q;
        unique case (state_q)
            ST_IDLE: begin
                if (strm.in_valid) begin
                    acc_d   = strm.in_data[0:7];
                    r_d     = strm.in_data[8:7+D];
                    for (int j = 0; j < D; j++) begin
                        b_d[j] = B_ext_MC[j];
                    end
                    k_d     = '0;
                    state_d = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                acc_d = acc_fold;
                k_d   = k_q + K_W'(1);
                if (k_q == K_W'(D - 1)) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (strm.out_ready) begin
                    byte_cnt_d = (byte_cnt_q == LAST_CNT) ? '0 : byte_cnt_q + CNT_W'(1);
                    // Wipe mask material so nothing carries over to the next byte.
                    acc_d   = '0;
                    r_d     = '0;
                    b_d     = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (clear) begin
            state_d    = ST_IDLE;
            k_d        = '0;
            byte_cnt_d = '0;
            acc_d      = '0;
            r_d        = '0;
            b_d        = '0;
        end
    end

    always_comb begin
        strm.in_ready  = (state_q == ST_IDLE);
        strm.out_valid = (state_q == ST_HOLD);
        strm.out_data  = '0;
        strm.out_last  = 1'b0;
        if (state_q == ST_HOLD) begin
            strm.out_data = acc_q;
            strm.out_last = (byte_cnt_q == LAST_CNT);
        end
        busy = (state_q != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_clm_unmask_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_clm_unmask_serial
// Brief    : Self-checking bench for clm_unmask_serial against a formula model.
// Revision : 1.0
// ============================================================================
module tb_clm_unmask_serial;
    import clm_unmask_serial_pkg::*;

    localparam int NB = 16;

    logic         clk;
    logic         rst;
    logic         clear;
    logic         busy;
    mc_m_matrix_t B_ext;

    int checks;
    int errors;
    int model_cnt;

    clm_unmask_serial_if bus ();

    clm_unmask_serial #(.NBYTES(NB)) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .B_ext_MC (B_ext),
        .strm     (bus.slave),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // plain[i] = in[i] ^ XOR_j (in[8+j] & B[j][i])
    function automatic plain_byte_t ref_decode(input state_t x, input mc_m_matrix_t b);
        plain_byte_t p;
        bit t;
        for (int i = 0; i < 8; i++) begin
            t = x[i];
            for (int j = 0; j < D; j++) t = t ^ (x[8+j] & b[j][i]);
            p[i] = t;
        end
        return p;
    endfunction

    function automatic mc_m_matrix_t spec_b();
        mc_m_matrix_t b;
        b = mc_m_matrix_t'({$urandom, $urandom, $urandom});
        b[0] = 8'h1B;
        b[1] = 8'h36;
        return b;
    endfunction

    function automatic mc_m_matrix_t rand_b();
        return mc_m_matrix_t'({$urandom, $urandom, $urandom});
    endfunction

    // Drives one byte through the DUT; returns what was observed at the output.
    task automatic do_byte(input state_t din, input mc_m_matrix_t b_after, input int stall,
                           output plain_byte_t data, output logic last,
                           output int lat, output bit stable);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_data   = din;
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_data  = state_t'($urandom);
        B_ext        = b_after;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        data   = bus.out_data;
        last   = bus.out_last;
        stable = 1'b1;
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            if (bus.out_data !== data || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
                stable = 1'b0;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.in_data = '0;
        B_ext = spec_b();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got %h want 00", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b want 0", bus.out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        rst = 1'b0;
        model_cnt = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        state_t      din [4];
        plain_byte_t want [4];
        plain_byte_t got;
        logic        last;
        int          lat;
        bit          stable;
        mc_m_matrix_t b;
        din[0] = {8'hA5, 2'b11}; want[0] = 8'h88;
        din[1] = {8'hA5, 2'b10}; want[1] = 8'hBE;
        din[2] = {8'hA5, 2'b01}; want[2] = 8'h93;
        din[3] = {8'hA5, 2'b00}; want[3] = 8'hA5;
        b = spec_b();
        B_ext = b;
        for (int v = 0; v < 4; v++) begin
            do_byte(din[v], b, 0, got, last, lat, stable);
            checks++; if (got !== want[v]) begin errors++; $display("FAIL vector%0d_data got %h want %h", v, got, want[v]); end
            checks++; if (lat != D + 1) begin errors++; $display("FAIL vector%0d_latency got %0d want %0d", v, lat, D + 1); end
            checks++; if (last !== (model_cnt == NB - 1)) begin errors++; $display("FAIL vector%0d_last got %b want %b", v, last, model_cnt == NB - 1); end
            model_cnt = (model_cnt + 1) % NB;
        end
    endtask

    task automatic test_stream_last();
        plain_byte_t got;
        logic        last;
        int          lat;
        bit          stable;
        state_t      din;
        mc_m_matrix_t b;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_cnt = 0;
        for (int i = 0; i < NB + 1; i++) begin
            din = state_t'($urandom);
            b = rand_b();
            B_ext = b;
            do_byte(din, b, 0, got, last, lat, stable);
            checks++; if (got !== ref_decode(din, b)) begin errors++; $display("FAIL stream%0d_data got %h want %h", i, got, ref_decode(din, b)); end
            checks++; if (last !== (i == NB - 1)) begin errors++; $display("FAIL stream%0d_last got %b want %b", i, last, i == NB - 1); end
            model_cnt = (model_cnt + 1) % NB;
        end
    endtask

    task automatic test_hold_stall();
        plain_byte_t got;
        logic        last;
        int          lat;
        bit          stable;
        mc_m_matrix_t b;
        b = spec_b();
        B_ext = b;
        do_byte({8'hA5, 2'b11}, b, 5, got, last, lat, stable);
        checks++; if (got !== 8'h88) begin errors++; $display("FAIL hold_data got %h want 88", got); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL hold_stable got %b want 1", stable); end
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_single_handshake got valid=%b busy=%b want 0/0", bus.out_valid, busy);
        end
        checks++; if (last !== (model_cnt == NB - 1)) begin errors++; $display("FAIL hold_last got %b want %b", last, model_cnt == NB - 1); end
        model_cnt = (model_cnt + 1) % NB;
    endtask

    task automatic test_b_change();
        plain_byte_t got;
        logic        last;
        int          lat;
        bit          stable;
        mc_m_matrix_t b;
        B_ext = spec_b();
        b = '1;
        do_byte({8'hA5, 2'b11}, b, 0, got, last, lat, stable);
        checks++; if (got !== 8'h88) begin errors++; $display("FAIL bchange_data got %h want 88", got); end
        model_cnt = (model_cnt + 1) % NB;
        B_ext = spec_b();
    endtask

    task automatic test_clear();
        plain_byte_t got;
        logic        last;
        int          lat;
        bit          stable;
        int          n;
        mc_m_matrix_t b;
        b = spec_b();
        B_ext = b;
        bus.in_valid = 1'b1; bus.in_data = {8'hA5, 2'b11};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL clear_reach_hold got %b want 1", bus.out_valid); end
        clear = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; bus.out_ready = 1'b0;
        model_cnt = 0;
        checks++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL clear_hold got valid=%b busy=%b ready=%b want 0/0/1", bus.out_valid, busy, bus.in_ready);
        end
        // Abort in ACCUM: byte must vanish and the next one decode without residue.
        bus.in_valid = 1'b1; bus.in_data = {8'h5A, 2'b11};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        checks++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL clear_accum got busy=%b valid=%b want 0/0", busy, bus.out_valid);
        end
        do_byte({8'h3C, 2'b01}, b, 0, got, last, lat, stable);
        checks++; if (got !== ref_decode({8'h3C, 2'b01}, b)) begin errors++; $display("FAIL clear_next_data got %h want %h", got, ref_decode({8'h3C, 2'b01}, b)); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL clear_next_last got %b want 0", last); end
        model_cnt = (model_cnt + 1) % NB;
    endtask

    task automatic test_rst_mid();
        plain_byte_t got;
        logic        last;
        int          lat;
        bit          stable;
        mc_m_matrix_t b;
        b = spec_b();
        B_ext = b;
        bus.in_valid = 1'b1; bus.in_data = {8'hA5, 2'b11};
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
                      bus.out_data !== 8'h00 || bus.out_last !== 1'b0) begin
            errors++; $display("FAIL rst_mid got busy=%b ready=%b valid=%b data=%h last=%b want 0/1/0/00/0",
                               busy, bus.in_ready, bus.out_valid, bus.out_data, bus.out_last);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_cnt = 0;
        do_byte({8'hA5, 2'b10}, b, 0, got, last, lat, stable);
        checks++; if (got !== 8'hBE) begin errors++; $display("FAIL rst_next_data got %h want BE", got); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL rst_next_last got %b want 0", last); end
        model_cnt = (model_cnt + 1) % NB;
    endtask

    task automatic test_random();
        plain_byte_t got;
        logic        last;
        int          lat;
        bit          stable;
        int          stall;
        state_t      din;
        mc_m_matrix_t b;
        for (int i = 0; i < 40; i++) begin
            din   = state_t'($urandom);
            b     = rand_b();
            stall = int'($urandom_range(0, 3));
            B_ext = b;
            do_byte(din, (($urandom & 1) != 0) ? rand_b() : b, stall, got, last, lat, stable);
            checks++; if (got !== ref_decode(din, b)) begin errors++; $display("FAIL rand%0d_data got %h want %h", i, got, ref_decode(din, b)); end
            checks++; if (last !== (model_cnt == NB - 1)) begin errors++; $display("FAIL rand%0d_last got %b want %b", i, last, model_cnt == NB - 1); end
            checks++; if (lat != D + 1) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", i, lat, D + 1); end
            checks++; if (stable !== 1'b1) begin errors++; $display("FAIL rand%0d_stable got %b want 1", i, stable); end
            model_cnt = (model_cnt + 1) % NB;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_cnt = 0;
        test_reset();
        test_vectors();
        test_stream_last();
        test_hold_stall();
        test_b_change();
        test_clear();
        test_rst_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
